// File: rtl/triple_watchdog.sv
// Three independent watchdog timers sharing one prescaler, with any/majority/all voting.
// Optional early-warning output enabled by defining WATCHDOG_WARN_EN.

module triple_watchdog_chan #(
    parameter logic [7:0] DEFAULT_TIMEOUT = 8'd100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       armed,
    input  logic       tick,
    input  logic       load,
    input  logic       kick,
    input  logic [7:0] load_val,
    output logic       bite,
    output logic       warn
);
    logic [7:0] timeout;
    logic [7:0] cnt;

    // Load outranks disarm so a timeout can be programmed before arming.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout <= DEFAULT_TIMEOUT;
            cnt     <= DEFAULT_TIMEOUT;
            bite    <= 1'b0;
        end else if (load) begin
            timeout <= load_val;
            cnt     <= load_val;
            bite    <= 1'b0;
        end else if (!armed || kick) begin
            cnt  <= timeout;
            bite <= 1'b0;
        end else if (tick) begin
            if (cnt > 8'd1) begin
                cnt <= cnt - 8'd1;
            end else begin
                cnt  <= 8'd0;
                bite <= 1'b1;
            end
        end
    end

`ifdef WATCHDOG_WARN_EN
    assign warn = armed & ~bite & (cnt != 8'd0) & (cnt <= (timeout >> 2));
`else
    assign warn = 1'b0;
`endif
endmodule

module triple_watchdog #(
    parameter int         PRESCALE_W      = 8,
    parameter logic [7:0] DEFAULT_TIMEOUT = 8'd100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int NUM_LANES = 3;

    logic                  armed;
    logic                  tick;
    logic [PRESCALE_W-1:0] presc;
    logic [NUM_LANES-1:0]  kick_prev;
    logic                  strobe_prev;
    logic [NUM_LANES-1:0]  kick_edge;
    logic                  load_edge;
    logic [NUM_LANES-1:0]  bite;
    logic [NUM_LANES-1:0]  warn;
    logic                  unused_ui;

    assign armed     = ui_in[7] & ena;
    assign tick      = armed & (&presc);
    assign kick_edge = ui_in[2:0] & ~kick_prev;
    assign load_edge = ui_in[6] & ~strobe_prev;
    assign unused_ui = ui_in[3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc       <= '0;
            kick_prev   <= '0;
            strobe_prev <= 1'b0;
        end else begin
            presc       <= armed ? presc + 1'b1 : '0;
            kick_prev   <= ui_in[2:0];
            strobe_prev <= ui_in[6];
        end
    end

    // Select 3 broadcasts a load to every channel.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_chan
        logic load_hit;
        assign load_hit = load_edge & ((ui_in[5:4] == 2'(i)) | (ui_in[5:4] == 2'd3));

        triple_watchdog_chan #(.DEFAULT_TIMEOUT(DEFAULT_TIMEOUT)) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .armed    (armed),
            .tick     (tick),
            .load     (load_hit),
            .kick     (kick_edge[i]),
            .load_val (uio_in),
            .bite     (bite[i]),
            .warn     (warn[i])
        );
    end

    assign uo_out = {1'b0, |warn, &bite,
                     (bite[0] & bite[1]) | (bite[0] & bite[2]) | (bite[1] & bite[2]),
                     |bite, bite};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
endmodule

// File: tb/tb_triple_watchdog.sv
// Randomized bench for triple_watchdog against a tick-elapsed reference model.
// Define WATCHDOG_WARN_EN to also check the early-warning bit.

module tb_triple_watchdog;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a channel bites once max(timeout,1) ticks have elapsed since its last restart.
    int   m_to[3];
    int   m_start[3];
    int   m_ticks;
    int   m_phase;
    logic [2:0] m_kprev;
    logic       m_sprev;

    triple_watchdog dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic       armed;
        logic [2:0] kedge;
        logic       sedge;
        armed = ui_in[7] & ena;
        kedge = ui_in[2:0] & ~m_kprev;
        sedge = ui_in[6] & ~m_sprev;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_to[i] = 100;
                m_start[i] = 0;
            end
            m_ticks = 0;
            m_phase = 0;
            m_kprev = '0;
            m_sprev = 1'b0;
            return;
        end
        m_kprev = ui_in[2:0];
        m_sprev = ui_in[6];
        if (armed) begin
            if (m_phase == 255) m_ticks++;
            m_phase = (m_phase + 1) % 256;
        end else begin
            m_phase = 0;
        end
        for (int i = 0; i < 3; i++) begin
            if (sedge && (ui_in[5:4] == 2'(i) || ui_in[5:4] == 2'd3)) begin
                m_to[i] = int'(uio_in);
                m_start[i] = m_ticks;
            end else if (!armed || kedge[i]) begin
                m_start[i] = m_ticks;
            end
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [2:0] b;
        logic       w;
        int         el, lim, cnt, nb;
        w  = 1'b0;
        nb = 0;
        for (int i = 0; i < 3; i++) begin
            el  = m_ticks - m_start[i];
            lim = (m_to[i] == 0) ? 1 : m_to[i];
            b[i] = (el >= lim);
            cnt = (b[i] || m_to[i] == 0) ? 0 : m_to[i] - el;
            if (b[i]) nb++;
`ifdef WATCHDOG_WARN_EN
            if (ui_in[7] && ena && !b[i] && cnt != 0 && cnt <= (m_to[i] / 4)) w = 1'b1;
`endif
        end
        return {1'b0, w, nb == 3, nb >= 2, nb >= 1, b};
    endfunction

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        chk(tag, uo_out, model_out());
    endtask

    int dis_cnt;

    initial begin
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        for (int i = 0; i < 3; i++) step("reset");
        chk("reset_uo", uo_out, 8'h00);
        chk("uio_out", uio_out, 8'h00);
        chk("uio_oe", uio_oe, 8'h00);

        // Armed, never kicked: all three bite on the 100th tick.
        rst_n = 1'b1;
        ui_in = 8'h80;
        for (int c = 0; c < 99 * 256; c++) step("free_run");
        chk("tick99_no_bite", {2'b00, uo_out[5:0]}, 8'h00);
        for (int c = 0; c < 256; c++) step("free_run");
        chk("tick100_bite", uo_out, 8'h3F);

        // Directed: load WD0=3, keep others kicked -> only WD0 bites, uo_out=09.
        ui_in = 8'hC0; uio_in = 8'd3; step("load0");
        ui_in = 8'h86; step("kick12");
        ui_in = 8'h80;
        for (int c = 0; c < 3 * 256 + 2; c++) step("wd0_run");
        chk("only_wd0", uo_out, 8'h09);
        ui_in = 8'h81; step("kick0");
        chk("kick_clears", uo_out[2:0], 3'b000);

        // Disarm with bites set.
        ui_in = 8'h00; step("disarm");
        chk("disarm_zero", uo_out, 8'h00);
        for (int c = 0; c < 600; c++) step("held_disarm");
        chk("still_zero", uo_out, 8'h00);

        // Randomized phase: small timeouts, sparse kicks/loads, occasional disarm/ena drop/reset.
        dis_cnt = 0;
        for (int c = 0; c < 38000; c++) begin
            logic [7:0] u;
            u = 8'h80;
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 349) == 0) u[i] = 1'b1;
            if ($urandom_range(0, 999) == 0) begin
                u[6] = 1'b1;
                u[5:4] = 2'($urandom_range(0, 3));
                uio_in = 8'($urandom_range(0, 6));
            end
            if (dis_cnt == 0 && $urandom_range(0, 2999) == 0) dis_cnt = $urandom_range(1, 30);
            ena = 1'b1;
            if (dis_cnt > 0) begin
                dis_cnt--;
                if (dis_cnt[0]) u[7] = 1'b0;
                else ena = 1'b0;
            end
            rst_n = !(c == 20000 || c == 20001);
            ui_in = u;
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
